// File: rtl/mac_mon_pkg.sv
// Shared types and helpers for the approximate-MAC error monitors.
package mac_mon_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned EXACT_W    = 2 * DATA_W_DEF + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [31:0] val;
        logic        sat;
    } sat_sum_t;

    // Adds inc to acc and clamps to 2^width-1; sat reports that clamping occurred.
    function automatic sat_sum_t sat_add(
        input logic [31:0] acc,
        input logic [31:0] inc,
        input int unsigned width
    );
        sat_sum_t    res;
        logic [32:0] full;
        logic [32:0] lim;
        full = {1'b0, acc} + {1'b0, inc};
        lim  = (33'd1 << width) - 33'd1;
        if (full > lim) begin
            res.val = lim[31:0];
            res.sat = 1'b1;
        end else begin
            res.val = full[31:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_exact_err.sv
// Combinational exact a*b+c and absolute deviation of an approximate result r.
module mac_exact_err #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned R_W     = 8,
    parameter int unsigned EXACT_W = 2 * DATA_W + 1
) (
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [DATA_W-1:0]  c,
    input  logic [R_W-1:0]     r,
    output logic [EXACT_W-1:0] exact,
    output logic [EXACT_W-1:0] err
);

    logic [EXACT_W-1:0] r_ext;

    always_comb begin
        exact = EXACT_W'(a) * EXACT_W'(b) + EXACT_W'(c);
        r_ext = EXACT_W'(r);
        if (r_ext >= exact) begin
            err = r_ext - exact;
        end else begin
            err = exact - r_ext;
        end
    end

endmodule

// File: rtl/mac_err_monitor.sv
// Windowed error-statistics monitor for the approximate 4x4 MAC stage:
// two-stage check pipeline, working accumulators and latched window results.
module mac_err_monitor
    import mac_mon_pkg::*;
#(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned R_W     = 8,
    parameter int unsigned WIN_LEN = 256,
    parameter int unsigned SUM_W   = 16,
    parameter int unsigned CNT_W   = $clog2(WIN_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    input  logic [DATA_W-1:0]   in_c,
    input  logic [R_W-1:0]      in_r,
    output logic                busy,
    output logic                done,
    output logic [SUM_W-1:0]    err_sum,
    output logic [2*DATA_W:0]   err_max,
    output logic [CNT_W-1:0]    mismatch_cnt,
    output logic                sum_sat
);

    localparam int unsigned EW = 2 * DATA_W + 1;

    state_e state_q, state_d;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d;
    logic [DATA_W-1:0] s1_b_q, s1_b_d;
    logic [DATA_W-1:0] s1_c_q, s1_c_d;
    logic [R_W-1:0]    s1_r_q, s1_r_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUM_W-1:0]  wsum_q, wsum_d;
    logic [EW-1:0]     wmax_q, wmax_d;
    logic [CNT_W-1:0]  wmis_q, wmis_d;
    logic              wsat_q, wsat_d;

    logic [SUM_W-1:0]  err_sum_q, err_sum_d;
    logic [EW-1:0]     err_max_q, err_max_d;
    logic [CNT_W-1:0]  mismatch_cnt_q, mismatch_cnt_d;
    logic              sum_sat_q, sum_sat_d;
    logic              done_q, done_d;

    logic [EW-1:0]     exact_s2;
    logic [EW-1:0]     err_s2;
    sat_sum_t          sum_next;

    logic accept_take;
    logic start_go;
    logic last_accept;
    logic finish;

    mac_exact_err #(
        .DATA_W  (DATA_W),
        .R_W     (R_W),
        .EXACT_W (EW)
    ) u_exact_err (
        .a     (s1_a_q),
        .b     (s1_b_q),
        .c     (s1_c_q),
        .r     (s1_r_q),
        .exact (exact_s2),
        .err   (err_s2)
    );

    assign sum_next = sat_add(32'(wsum_q), 32'(err_s2), SUM_W);

    // Abort has priority over every other event in the same cycle.
    always_comb begin
        accept_take = (state_q == RUN) && in_valid && !abort;
        start_go    = (state_q == IDLE) && start && !abort;
        last_accept = accept_take && (cnt_q == CNT_W'(WIN_LEN - 1));
        finish      = (state_q == DRAIN) && !abort && !s1_valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_go) state_d = RUN;
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_accept) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   if (abort || finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == RUN);
        busy     = (state_q == RUN) || (state_q == DRAIN);
    end

    always_comb begin
        s1_valid_d     = accept_take;
        s1_a_d         = s1_a_q;
        s1_b_d         = s1_b_q;
        s1_c_d         = s1_c_q;
        s1_r_d         = s1_r_q;
        cnt_d          = cnt_q;
        wsum_d         = wsum_q;
        wmax_d         = wmax_q;
        wmis_d         = wmis_q;
        wsat_d         = wsat_q;
        err_sum_d      = err_sum_q;
        err_max_d      = err_max_q;
        mismatch_cnt_d = mismatch_cnt_q;
        sum_sat_d      = sum_sat_q;
        done_d         = finish;

        if (accept_take) begin
            s1_a_d = in_a;
            s1_b_d = in_b;
            s1_c_d = in_c;
            s1_r_d = in_r;
            cnt_d  = cnt_q + CNT_W'(1);
        end

        if (start_go) begin
            cnt_d  = '0;
            wsum_d = '0;
            wmax_d = '0;
            wmis_d = '0;
            wsat_d = 1'b0;
        end else if (s1_valid_q && !abort) begin
            wsum_d = SUM_W'(sum_next.val);
            wsat_d = wsat_q | sum_next.sat;
            if (err_s2 > wmax_q) begin
                wmax_d = err_s2;
            end
            if (EW'(s1_r_q) != exact_s2) begin
                wmis_d = wmis_q + CNT_W'(1);
            end
        end

        if (finish) begin
            err_sum_d      = wsum_q;
            err_max_d      = wmax_q;
            mismatch_cnt_d = wmis_q;
            sum_sat_d      = wsat_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_a_q         <= '0;
            s1_b_q         <= '0;
            s1_c_q         <= '0;
            s1_r_q         <= '0;
            cnt_q          <= '0;
            wsum_q         <= '0;
            wmax_q         <= '0;
            wmis_q         <= '0;
            wsat_q         <= 1'b0;
            err_sum_q      <= '0;
            err_max_q      <= '0;
            mismatch_cnt_q <= '0;
            sum_sat_q      <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_a_q         <= s1_a_d;
            s1_b_q         <= s1_b_d;
            s1_c_q         <= s1_c_d;
            s1_r_q         <= s1_r_d;
            cnt_q          <= cnt_d;
            wsum_q         <= wsum_d;
            wmax_q         <= wmax_d;
            wmis_q         <= wmis_d;
            wsat_q         <= wsat_d;
            err_sum_q      <= err_sum_d;
            err_max_q      <= err_max_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            sum_sat_q      <= sum_sat_d;
            done_q         <= done_d;
        end
    end

    assign done         = done_q;
    assign err_sum      = err_sum_q;
    assign err_max      = err_max_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign sum_sat      = sum_sat_q;

endmodule

// File: tb/tb_mac_err_monitor.sv
// Scoreboard bench for mac_err_monitor: windows of directed samples push expected
// results; a negedge monitor pops and checks them whenever done pulses.
module tb_mac_err_monitor;

    localparam int unsigned WIN = 4;
    localparam int unsigned SW  = 4;
    localparam int unsigned CW  = $clog2(WIN + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_a = '0;
    logic [3:0]    in_b = '0;
    logic [3:0]    in_c = '0;
    logic [7:0]    in_r = '0;
    logic          busy;
    logic          done;
    logic [SW-1:0] err_sum;
    logic [8:0]    err_max;
    logic [CW-1:0] mismatch_cnt;
    logic          sum_sat;

    typedef struct {
        int sum;
        int mx;
        int mis;
        int sat;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;

    mac_err_monitor #(
        .DATA_W  (4),
        .R_W     (8),
        .WIN_LEN (WIN),
        .SUM_W   (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_c         (in_c),
        .in_r         (in_r),
        .busy         (busy),
        .done         (done),
        .err_sum      (err_sum),
        .err_max      (err_max),
        .mismatch_cnt (mismatch_cnt),
        .sum_sat      (sum_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected window result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("err_sum", int'(err_sum), e.sum);
                chk("err_max", int'(err_max), e.mx);
                chk("mismatch_cnt", int'(mismatch_cnt), e.mis);
                chk("sum_sat", int'(sum_sat), e.sat);
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following the accept.
    task automatic send(input int a, input int b, input int c, input int r, input int gap);
        int guard = 0;
        repeat (gap) @(negedge clk);
        in_a     = 4'(a);
        in_b     = 4'(b);
        in_c     = 4'(c);
        in_r     = 8'(r);
        in_valid = 1'b1;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_exp(input int sum, input int mx, input int mis, input int sat);
        sb.push_back('{sum, mx, mis, sat, acc_cyc + 3});
    endtask

    task automatic start_win();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_drain();
        repeat (5) @(negedge clk);
        chk("window_closed", sb.size(), 0);
        sb.delete();
        chk("idle_after_window", int'(busy), 0);
    endtask

    task automatic chk_outputs(input string tag, input int sum, input int mx, input int mis, input int sat);
        chk({tag, "_err_sum"}, int'(err_sum), sum);
        chk({tag, "_err_max"}, int'(err_max), mx);
        chk({tag, "_mismatch"}, int'(mismatch_cnt), mis);
        chk({tag, "_sum_sat"}, int'(sum_sat), sat);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset values and inert IDLE
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk_outputs("rst", 0, 0, 0, 0);
        in_valid = 1'b1;
        in_r     = 8'h55;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", int'(in_ready), 0);
        chk("idle_busy", int'(busy), 0);
        chk_outputs("idle", 0, 0, 0, 0);

        // Exact window: 3*5+2 = 17 every time
        start_win();
        for (int i = 0; i < 4; i++) send(3, 5, 2, 17, 0);
        push_exp(0, 0, 0, 0);
        wait_drain();

        // Errors 0, 8, 2, 1
        start_win();
        send(15, 15, 15, 240, 0);
        send(15, 15, 15, 232, 0);
        send(2, 3, 1, 9, 0);
        send(0, 0, 0, 1, 0);
        push_exp(11, 8, 3, 0);
        wait_drain();

        // Abort after two accepts: no done, results retained
        start_win();
        send(0, 0, 0, 200, 0);
        send(0, 0, 0, 200, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_ready", int'(in_ready), 0);
        chk("abort_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        chk_outputs("abort", 11, 8, 3, 0);

        // abort and start together in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_wins_busy", int'(busy), 0);

        // Saturation: four errors of 8 against a 4-bit sum
        start_win();
        for (int i = 0; i < 4; i++) send(0, 0, 0, 8, 0);
        push_exp(15, 8, 4, 1);
        wait_drain();

        // Gapped handshake; start pulses in RUN and DRAIN are ignored
        start_win();
        send(1, 2, 3, 5, int'($urandom_range(0, 2)));
        chk("gap_ready_0", int'(in_ready), 1);
        send(2, 2, 3, 9, int'($urandom_range(0, 2)));
        chk("gap_ready_1", int'(in_ready), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(3, 2, 3, 5, int'($urandom_range(0, 2)));
        chk("gap_ready_2", int'(in_ready), 1);
        send(4, 2, 3, 11, int'($urandom_range(0, 2)));
        chk("gap_ready_3", int'(in_ready), 0);
        push_exp(6, 4, 2, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Reset mid-window returns everything to zero
        start_win();
        send(1, 1, 1, 0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk_outputs("midrst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_done", int'(done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
